// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD tile-map write arbiter.
package osd_pkg;

    // Arbiter FSM states. CLEAR is only reachable when the clear engine is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } osd_arb_state_t;

    // Requester identity: A = SPI host bus, B = on-chip status text writer.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } osd_req_id_t;

    // Byte the clear engine writes into every tile (ASCII space).
    localparam logic [7:0] OSD_CLEAR_CHAR = 8'h20;

    // Number of tiles in a cx-by-cy character map.
    function automatic int unsigned osd_tiles(input int unsigned cx, input int unsigned cy);
        return cx * cy;
    endfunction

endpackage

// File: rtl/osd_rr_arb2.sv
// Combinational two-way round-robin pick. A lone request always wins;
// on a tie the requester that did not win last time is chosen.
module osd_rr_arb2
    import osd_pkg::*;
(
    input  logic        req_a_i,
    input  logic        req_b_i,
    input  osd_req_id_t last_grant_i,
    output logic        valid_o,
    output osd_req_id_t grant_o
);

    // Pick a winner from the two request lines and the previous winner.
    always_comb begin
        valid_o = req_a_i | req_b_i;
        grant_o = REQ_A;
        if (req_a_i && req_b_i) begin
            grant_o = (last_grant_i == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b_i) begin
            grant_o = REQ_B;
        end
    end

endmodule

// File: rtl/osd_tile_write_arbiter.sv
// Sole write master for the OSD tile map. Shares the single write port
// between requester A (SPI host) and requester B (status text writer) with
// round-robin arbitration and a req/ack handshake; out-of-range addresses
// are acknowledged but dropped. The optional full-map clear engine is
// compiled in when the macro OSD_CLEAR_EN is defined.
module osd_tile_write_arbiter
    import osd_pkg::*;
#(
    parameter int unsigned c_chars_x    = 64,
    parameter int unsigned c_chars_y    = 24,
    parameter int unsigned c_addr_bits  = 11,
    parameter logic [7:0]  c_clear_char = OSD_CLEAR_CHAR
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   i_a_req,
    input  logic [c_addr_bits-1:0] i_a_addr,
    input  logic [7:0]             i_a_data,
    output logic                   o_a_ack,
    input  logic                   i_b_req,
    input  logic [c_addr_bits-1:0] i_b_addr,
    input  logic [7:0]             i_b_data,
    output logic                   o_b_ack,
    input  logic                   i_clear,
    output logic                   o_wr,
    output logic [c_addr_bits-1:0] o_addr,
    output logic [7:0]             o_data,
    output logic                   o_oob,
    output logic                   o_busy,
    output logic                   o_clear_done
);

    localparam int unsigned            N_TILES  = osd_tiles(c_chars_x, c_chars_y);
    // One extra bit so a map that exactly fills the address space still compares correctly.
    localparam logic [c_addr_bits:0]   TILES_W  = (c_addr_bits + 1)'(N_TILES);

    osd_arb_state_t          state_q, state_d;
    osd_req_id_t             last_grant_q, last_grant_d;
    osd_req_id_t             grant_q, grant_d;
    logic                    wr_q, wr_d;
    logic [c_addr_bits-1:0]  addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic                    a_ack_q, a_ack_d;
    logic                    b_ack_q, b_ack_d;
    logic                    oob_q, oob_d;
    logic                    busy_q, busy_d;

    logic                    pick_valid;
    osd_req_id_t             pick;
    logic [c_addr_bits-1:0]  sel_addr;
    logic [7:0]              sel_data;
    logic                    sel_in_range;

`ifdef OSD_CLEAR_EN
    localparam logic [c_addr_bits-1:0] LAST_ADDR = c_addr_bits'(N_TILES - 1);

    logic                    clear_pending_q, clear_pending_d;
    logic [c_addr_bits-1:0]  clr_cnt_q, clr_cnt_d;
    logic                    clear_last_q, clear_last_d;
    logic                    clear_done_q, clear_done_d;
`else
    logic                    unused_clear;
    assign unused_clear = i_clear ^ (^c_clear_char);
`endif

    // A requester whose ack is on the outputs this cycle still has req high;
    // masking it stops the same request from being granted twice.
    osd_rr_arb2 u_rr (
        .req_a_i      (i_a_req & ~a_ack_q),
        .req_b_i      (i_b_req & ~b_ack_q),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .grant_o      (pick)
    );

    // Inputs of the granted requester; they are held stable until its ack.
    assign sel_addr     = (grant_q == REQ_A) ? i_a_addr : i_b_addr;
    assign sel_data     = (grant_q == REQ_A) ? i_a_data : i_b_data;
    assign sel_in_range = ({1'b0, sel_addr} < TILES_W);

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        oob_d        = 1'b0;
`ifdef OSD_CLEAR_EN
        clear_pending_d = clear_pending_q;
        clr_cnt_d       = clr_cnt_q;
        clear_last_d    = 1'b0;
        clear_done_d    = clear_last_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef OSD_CLEAR_EN
                if (clear_pending_q || i_clear) begin
                    state_d         = CLEAR;
                    clear_pending_d = 1'b0;
                    clr_cnt_d       = '0;
                end else
`endif
                if (pick_valid) begin
                    state_d      = WRITE;
                    grant_d      = pick;
                    last_grant_d = pick;
                end
            end
            WRITE: begin
                a_ack_d = (grant_q == REQ_A);
                b_ack_d = (grant_q == REQ_B);
                if (sel_in_range) begin
                    wr_d   = 1'b1;
                    addr_d = sel_addr;
                    data_d = sel_data;
                end else begin
                    oob_d  = 1'b1;
                end
                state_d = IDLE;
`ifdef OSD_CLEAR_EN
                if (i_clear) begin
                    clear_pending_d = 1'b1;
                end
`endif
            end
`ifdef OSD_CLEAR_EN
            CLEAR: begin
                wr_d   = 1'b1;
                addr_d = clr_cnt_q;
                data_d = c_clear_char;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d      = IDLE;
                    clear_last_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_B;
            grant_q      <= REQ_A;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            oob_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            oob_q        <= oob_d;
            busy_q       <= busy_d;
        end
    end

`ifdef OSD_CLEAR_EN
    // Clear engine registers: pending flag, address counter and done pipeline.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            clear_pending_q <= 1'b0;
            clr_cnt_q       <= '0;
            clear_last_q    <= 1'b0;
            clear_done_q    <= 1'b0;
        end else begin
            clear_pending_q <= clear_pending_d;
            clr_cnt_q       <= clr_cnt_d;
            clear_last_q    <= clear_last_d;
            clear_done_q    <= clear_done_d;
        end
    end

    assign o_clear_done = clear_done_q;
`else
    assign o_clear_done = 1'b0;
`endif

    assign o_wr    = wr_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;
    assign o_a_ack = a_ack_q;
    assign o_b_ack = b_ack_q;
    assign o_oob   = oob_q;
    assign o_busy  = busy_q;

endmodule
